uart_rx_line_conditioner: RTL

Conditions the raw asynchronous UART receive pin before it reaches the UART-AXI4 bridge's `uart_rx` input. The block provides:
- metastability synchronisation and a run-length glitch filter;
- line-state supervision: idle detection, break detection, and a saturating glitch statistic.

It sits between the top-level `uart_rx` pad and the bridge. Its status outputs are intended for the register block's status inputs.

---
 rtl/uart_rx_line_conditioner.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_line_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_line_conditioner
// Purpose  : Synchronises and de-glitches the raw UART receive pad, and
//            supervises the line for idle and break conditions. It also keeps
//            a saturating count of rejected glitches.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_line_conditioner #(
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int IDLE_BITS   = 10,
    parameter int BREAK_BITS  = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_async,
    input  logic       clr_stats,
    output logic       rx_clean,
    output logic       line_idle,
    output logic       break_det,
    output logic       break_active,
    output logic [7:0] glitch_count
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
    localparam int IDLE_MAX   = IDLE_BITS * BIT_CYCLES;
    localparam int BREAK_MAX  = BREAK_BITS * BIT_CYCLES;
    localparam int HI_W       = $clog2(IDLE_MAX + 1);
    localparam int LO_W       = $clog2(BREAK_MAX + 1);
    // The run counter must be able to hold FILTER_LEN for the compare.
    localparam int RUN_W      = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    localparam logic [HI_W-1:0]  HI_SAT    = HI_W'(IDLE_MAX);
    localparam logic [LO_W-1:0]  LO_SAT    = LO_W'(BREAK_MAX);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(FILTER_LEN);
    localparam logic [7:0]       GLITCH_SAT = 8'hFF;

    // ------------------------------------------------------------------------
    // Line supervision states
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_BREAK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    logic [RUN_W-1:0]       run_cnt;
    logic [RUN_W-1:0]       run_inc;
    logic [RUN_W-1:0]       run_cnt_nxt;
    logic                   mismatch;
    logic                   filt_toggle;
    logic                   glitch;

    logic [HI_W-1:0]        hi_cnt;
    logic [LO_W-1:0]        lo_cnt;

    state_t                 state;
    state_t                 state_nxt;
    logic                   enter_break;

    // ------------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------------
    // Shift the pad through the synchroniser chain; resets to the idle level.
    generate
        if (SYNC_STAGES > 1) begin : g_sync_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_async};
                end
            end
        end else begin : g_sync_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= uart_rx_async;
                end
            end
        end
    endgenerate

    assign sync_out = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Run-length glitch filter
    // ------------------------------------------------------------------------
    // Decide whether this cycle extends a disagreeing run, commits a toggle,
    // or ends a run early (which is a rejected glitch).
    always_comb begin
        mismatch    = (sync_out != rx_clean);
        run_inc     = run_cnt + RUN_W'(1);
        filt_toggle = 1'b0;
        glitch      = 1'b0;
        run_cnt_nxt = '0;
        if (mismatch) begin
            if (run_inc == RUN_LIMIT) begin
                filt_toggle = 1'b1;
                run_cnt_nxt = '0;
            end else begin
                run_cnt_nxt = run_inc;
            end
        end else begin
            glitch      = (run_cnt != '0);
            run_cnt_nxt = '0;
        end
    end

    // Register the run counter and the filtered line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt  <= '0;
            rx_clean <= 1'b1;
        end else begin
            run_cnt <= run_cnt_nxt;
            if (filt_toggle) begin
                rx_clean <= ~rx_clean;
            end
        end
    end

    // Saturating glitch statistic; a clear request overrides a new glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_count <= 8'd0;
        end else if (clr_stats) begin
            glitch_count <= 8'd0;
        end else if (glitch && (glitch_count != GLITCH_SAT)) begin
            glitch_count <= glitch_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Line level run counters
    // ------------------------------------------------------------------------
    // Count consecutive high and low cycles of the filtered line, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            if (rx_clean) begin
                if (hi_cnt != HI_SAT) begin
                    hi_cnt <= hi_cnt + HI_W'(1);
                end
                lo_cnt <= '0;
            end else begin
                if (lo_cnt != LO_SAT) begin
                    lo_cnt <= lo_cnt + LO_W'(1);
                end
                hi_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line supervision state machine
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACTIVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; break is only entered from ACTIVE so it fires once.
    always_comb begin
        state_nxt   = state;
        enter_break = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (hi_cnt == HI_SAT) begin
                    state_nxt = ST_IDLE;
                end else if (lo_cnt == LO_SAT) begin
                    state_nxt   = ST_BREAK;
                    enter_break = 1'b1;
                end
            end
            ST_IDLE: begin
                if (!rx_clean) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_BREAK: begin
                if (rx_clean) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt = ST_ACTIVE;
            end
        endcase
    end

    // Status outputs are flopped alongside the state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_idle    <= 1'b0;
            break_active <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            line_idle    <= (state_nxt == ST_IDLE);
            break_active <= (state_nxt == ST_BREAK);
            break_det    <= enter_break;
        end
    end

endmodule
`default_nettype wire
